parity_frame_unit: RTL and testbench
====================================

Name: parity_frame_unit

Overview:
- Streaming parity generator/checker; the parametrised successor to the per-word combinational parity function.
- Accepts a frame of DATA_W-bit words on a valid/ready input and folds every bit of the frame into one parity bit, in even or odd mode.
- Emits one result per frame on a valid/ready output: generated parity, check verdict against a received parity bit, and frame length.
- Sits between an address/data source and a downstream integrity monitor or bus encoder.

Parameters:
- DATA_W, 32, width of each input word in bits (>=1).
- MAX_WORDS, 16, maximum legal words per frame (>=1).
- CNT_W, 5, width of the length counter; must satisfy 2**CNT_W > MAX_WORDS.

Ports:
- clock  input  1  single system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- odd_mode  input  1  1 = odd parity, 0 = even parity; sampled on the first accepted beat of each frame.
- in_valid  input  1  input word valid.
- in_ready  output  1  unit can accept a word.
- in_data  input  DATA_W  input word.
- in_last  input  1  marks the final word of the frame.
- in_par  input  1  received parity bit; meaningful only on the in_last beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_parity  output  1  generated frame parity.
- out_mismatch  output  1  1 = in_par differs from the generated parity.
- out_too_long  output  1  frame exceeded MAX_WORDS.
- out_len  output  CNT_W  accepted words in the frame, saturating at MAX_WORDS+1.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - State goes to IDLE; accumulator and counter clear.
  - out_valid=0, out_parity=0, out_mismatch=0, out_too_long=0, out_len=0.
  - in_ready=0 while reset is asserted and 1 in the cycle after.
  - Reset mid-frame or mid-result discards all partial state; no result is produced.
- Handshakes:
  - Input beat accepted iff in_valid && in_ready at a clock edge.
  - Result consumed iff out_valid && out_ready.
  - out_valid and all out_* fields hold stable until consumed.
- State machine:
  - IDLE (in_ready=1): on an accepted beat, latch odd_mode into mode_r; acc <= ^in_data; len <= 1. If in_last, go to RESULT; otherwise go to ACCUM.
  - ACCUM (in_ready=1): on an accepted beat, acc <= acc ^ (^in_data); len <= len+1, saturating at MAX_WORDS+1. If in_last, go to RESULT.
  - RESULT (in_ready=0, out_valid=1): on out_ready, go to IDLE.
- Output registers are loaded on the in_last beat:
  - out_parity = acc_next ^ mode_r, where acc_next includes the last word. This makes the total count of 1s, including the parity bit, even (mode 0) or odd (mode 1).
  - out_mismatch = in_par != out_parity.
  - out_too_long = (len_next > MAX_WORDS).
  - out_len = len_next.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- Throughput: one word per clock inside a frame. There is one bubble per frame, because in_ready is low while in RESULT. Back-to-back frames are therefore accepted no faster than one cycle after the result is consumed.
- Boundary conditions:
  - Single-word frame: IDLE goes directly to RESULT.
  - Over-length frame: counting saturates at MAX_WORDS+1; the frame is still accumulated and terminated by in_last, with out_too_long=1.
  - odd_mode changes mid-frame: ignored; mode_r is held until the next frame.
  - in_valid without in_ready in RESULT: the word is not accepted; the source must hold it.
  - out_ready asserted while out_valid=0: no effect.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_RESULT=2'd2;
  - mode constants PAR_EVEN=1'b0, PAR_ODD=1'b1.
- One natural sub-module: parity_reduce, a combinational DATA_W-bit XOR-reduction of the word. It is the existing parity function made width-parameterised and is reused by other blocks.

Test Plan:
- Single word, even mode: in_data=32'h1, in_last=1, in_par=1 -> next cycle out_valid=1, out_parity=1, out_mismatch=0, out_len=1.
- Three-word frame, odd mode: words 32'd102, 32'd105, 32'd1032, in_par=0 -> out_parity=0^1=1, out_mismatch=1, out_len=3, out_too_long=0.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_* stable, in_ready=0 throughout. A new frame offered during this time is not accepted until the cycle after out_ready=1.
- Over-length: MAX_WORDS=16, send 20 words of 32'h3 -> out_parity=0 (even mode), out_too_long=1, out_len=17.
- Mode latch: start a frame with odd_mode=0, flip odd_mode to 1 on word 2 -> parity is computed in even mode.
- Reset mid-frame: assert reset after 2 of 4 words, then send a fresh 1-word frame 32'd157985 (even mode) -> out_parity=^32'd157985 and out_len=1; no stale result appears.

Source files
------------

// File: rtl/parity_frame_unit_pkg.sv
// Shared types and constants for the streaming frame parity unit.
package parity_frame_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_unit_reduce.sv
// Width-parameterised XOR reduction of one word; reused by other integrity blocks.
module parity_reduce #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] data,
   output logic              parity
);

   assign parity = ^data;

endmodule

// File: rtl/parity_frame_unit.sv
// Streaming frame parity generator/checker: folds every bit of a frame into one
// parity bit and reports it with a check verdict and the frame length.
module parity_frame_unit
   import parity_frame_unit_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MAX_WORDS = 16,
   parameter int CNT_W     = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              odd_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_par,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_parity,
   output logic              out_mismatch,
   output logic              out_too_long,
   output logic [CNT_W-1:0]  out_len
);

   localparam logic [CNT_W-1:0] LEN_SAT = CNT_W'(MAX_WORDS + 1);
   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_WORDS);

   state_t             state_r;
   logic               acc_r;
   logic [CNT_W-1:0]   len_r;
   logic               mode_r;
   logic               ready_r;
   logic               out_valid_r;
   logic               out_parity_r;
   logic               out_mismatch_r;
   logic               out_too_long_r;
   logic [CNT_W-1:0]   out_len_r;

   logic               word_par_s;
   logic               beat_s;
   logic               acc_next_s;
   logic               mode_cur_s;
   logic               par_next_s;
   logic [CNT_W-1:0]   len_next_s;

   parity_reduce #(.DATA_W(DATA_W)) u_reduce (
      .data   (in_data),
      .parity (word_par_s)
   );

   // Reset must block acceptance in the very cycle it is asserted.
   assign in_ready     = ready_r & ~reset;
   assign out_valid    = out_valid_r;
   assign out_parity   = out_parity_r;
   assign out_mismatch = out_mismatch_r;
   assign out_too_long = out_too_long_r;
   assign out_len      = out_len_r;

   // Next accumulator, length and mode as they would be after the current beat.
   always_comb begin
      beat_s     = in_valid & in_ready;
      acc_next_s = word_par_s;
      len_next_s = CNT_W'(1);
      mode_cur_s = odd_mode;
      if (state_r == ST_IDLE) begin
         acc_next_s = word_par_s;
         len_next_s = CNT_W'(1);
         mode_cur_s = odd_mode;
      end else begin
         acc_next_s = acc_r ^ word_par_s;
         mode_cur_s = mode_r;
         if (len_r == LEN_SAT) begin
            len_next_s = len_r;
         end else begin
            len_next_s = len_r + CNT_W'(1);
         end
      end
      par_next_s = acc_next_s ^ mode_cur_s;
   end

   // Frame state machine with registered result fields.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         acc_r          <= 1'b0;
         len_r          <= '0;
         mode_r         <= PAR_EVEN;
         ready_r        <= 1'b1;
         out_valid_r    <= 1'b0;
         out_parity_r   <= 1'b0;
         out_mismatch_r <= 1'b0;
         out_too_long_r <= 1'b0;
         out_len_r      <= '0;
      end else begin
         case (state_r)
            ST_IDLE, ST_ACCUM: begin
               if (beat_s) begin
                  acc_r <= acc_next_s;
                  len_r <= len_next_s;
                  if (state_r == ST_IDLE) begin
                     mode_r <= odd_mode;
                  end
                  if (in_last) begin
                     state_r        <= ST_RESULT;
                     ready_r        <= 1'b0;
                     out_valid_r    <= 1'b1;
                     out_parity_r   <= par_next_s;
                     out_mismatch_r <= in_par ^ par_next_s;
                     out_too_long_r <= (len_next_s > LEN_MAX);
                     out_len_r      <= len_next_s;
                  end else begin
                     state_r <= ST_ACCUM;
                  end
               end
            end
            ST_RESULT: begin
               if (out_ready) begin
                  state_r     <= ST_IDLE;
                  ready_r     <= 1'b1;
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               ready_r     <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_frame_unit.sv
// Self-checking bench for parity_frame_unit: directed table, corner sequences and
// randomized frames against a bit-counting reference model.
module tb_parity_frame_unit;

   localparam int DATA_W    = 32;
   localparam int MAX_WORDS = 16;
   localparam int CNT_W     = 5;

   logic              clock = 1'b0;
   logic              reset;
   logic              odd_mode;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_par;
   logic              out_valid;
   logic              out_ready;
   logic              out_parity;
   logic              out_mismatch;
   logic              out_too_long;
   logic [CNT_W-1:0]  out_len;

   int checks = 0;
   int errors = 0;
   logic [31:0] fw[$];

   parity_frame_unit #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .odd_mode(odd_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_par(in_par),
      .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
      .out_mismatch(out_mismatch), .out_too_long(out_too_long), .out_len(out_len)
   );

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int               n;
      logic [3:0][31:0] words;
      logic             mode;
      logic             par;
      logic             exp_parity;
      logic             exp_mismatch;
      logic [CNT_W-1:0] exp_len;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Total count of ones in the frame decides parity; mode inverts it.
   function automatic logic model_parity(input logic mode);
      int ones = 0;
      foreach (fw[i]) ones += $countones(fw[i]);
      return ((ones % 2) == 1) ? ~mode : mode;
   endfunction

   function automatic logic [CNT_W-1:0] model_len(input int n);
      return (n > MAX_WORDS) ? CNT_W'(MAX_WORDS + 1) : CNT_W'(n);
   endfunction

   task automatic send_word(input logic [31:0] d, input logic last, input logic par,
                            input logic mode, input int gap);
      int t = 0;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_par   = par;
      odd_mode = mode;
      while (!in_ready && t < 100) begin
         tick();
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input logic mode, input logic par, input bit flip, input bit gaps);
      for (int i = 0; i < fw.size(); i++) begin
         send_word(fw[i], (i == fw.size() - 1), par, (flip && i > 0) ? ~mode : mode,
                   gaps ? int'($urandom_range(0, 2)) : 0);
      end
   endtask

   task automatic take_result(input string name, input logic e_par, input logic e_mm,
                              input logic e_tl, input logic [CNT_W-1:0] e_len, input int hold);
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_parity"}, 32'(out_parity), 32'(e_par));
      check({name, "_mismatch"}, 32'(out_mismatch), 32'(e_mm));
      check({name, "_too_long"}, 32'(out_too_long), 32'(e_tl));
      check({name, "_len"}, 32'(out_len), 32'(e_len));
      repeat (hold) begin
         tick();
         check({name, "_hold"}, {30'd0, out_valid, out_parity}, {30'd0, 1'b1, e_par});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_consumed"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
   endtask

   vec_t vecs[5];

   initial begin
      reset = 1'b1; odd_mode = 1'b0; in_valid = 1'b0; in_data = '0;
      in_last = 1'b0; in_par = 1'b0; out_ready = 1'b0;

      vecs[0] = '{n: 1, words: {32'd0, 32'd0, 32'd0, 32'h1}, mode: 1'b0, par: 1'b1,
                  exp_parity: 1'b1, exp_mismatch: 1'b0, exp_len: 5'd1};
      vecs[1] = '{n: 3, words: {32'd0, 32'd1032, 32'd105, 32'd102}, mode: 1'b1, par: 1'b0,
                  exp_parity: 1'b1, exp_mismatch: 1'b1, exp_len: 5'd3};
      vecs[2] = '{n: 2, words: {32'd0, 32'd0, 32'h1, 32'hFFFF_FFFF}, mode: 1'b0, par: 1'b1,
                  exp_parity: 1'b1, exp_mismatch: 1'b0, exp_len: 5'd2};
      vecs[3] = '{n: 4, words: {32'd0, 32'd0, 32'd0, 32'd0}, mode: 1'b1, par: 1'b1,
                  exp_parity: 1'b1, exp_mismatch: 1'b0, exp_len: 5'd4};
      vecs[4] = '{n: 1, words: {32'd0, 32'd0, 32'd0, 32'h8000_0000}, mode: 1'b1, par: 1'b1,
                  exp_parity: 1'b0, exp_mismatch: 1'b1, exp_len: 5'd1};

      // Reset state
      repeat (3) tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_outs", {27'd0, out_valid, out_parity, out_mismatch, out_too_long, 1'b0} | 32'(out_len),
            32'd0);
      reset = 1'b0;
      #1;
      check("rst_release_ready", 32'(in_ready), 32'd1);

      // out_ready with nothing pending
      out_ready = 1'b1;
      tick(); tick();
      out_ready = 1'b0;
      check("idle_out_ready", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});

      // Directed table
      for (int v = 0; v < 5; v++) begin
         fw.delete();
         for (int i = 0; i < vecs[v].n; i++) fw.push_back(vecs[v].words[i]);
         send_frame(vecs[v].mode, vecs[v].par, 1'b0, 1'b0);
         take_result($sformatf("vec%0d", v), vecs[v].exp_parity, vecs[v].exp_mismatch,
                     1'b0, vecs[v].exp_len, 0);
      end

      // Backpressure: result held 5 cycles, offered word waits
      fw.delete(); fw.push_back(32'h7);
      send_frame(1'b0, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 32'h3; in_last = 1'b1; in_par = 1'b0; odd_mode = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_stable", {27'd0, out_valid, out_parity, out_mismatch, out_too_long, 1'b0} | 32'(out_len),
               {27'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0} | 32'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_after_consume", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      take_result("bp_next", 1'b0, 1'b0, 1'b0, 5'd1, 0);

      // Over-length frame
      fw.delete();
      repeat (20) fw.push_back(32'h3);
      send_frame(1'b0, 1'b0, 1'b0, 1'b0);
      take_result("overlen", 1'b0, 1'b0, 1'b1, 5'd17, 2);

      // Mode flip mid-frame is ignored: 3 ones total, even mode -> parity 1
      fw.delete(); fw.push_back(32'h1); fw.push_back(32'h1); fw.push_back(32'h1);
      send_frame(1'b0, 1'b1, 1'b1, 1'b0);
      take_result("mode_latch", 1'b1, 1'b0, 1'b0, 5'd3, 0);

      // Reset mid-frame
      send_word(32'hF0F0_0001, 1'b0, 1'b0, 1'b1, 0);
      send_word(32'h0000_0003, 1'b0, 1'b0, 1'b1, 0);
      reset = 1'b1;
      #1;
      check("midrst_ready", 32'(in_ready), 32'd0);
      tick(); tick();
      check("midrst_outs", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b0});
      reset = 1'b0;
      #1;
      fw.delete(); fw.push_back(32'd157985);
      send_frame(1'b0, 1'b0, 1'b0, 1'b0);
      take_result("midrst_fresh", model_parity(1'b0), model_parity(1'b0), 1'b0, 5'd1, 0);

      // Randomized frames against the model
      for (int f = 0; f < 40; f++) begin
         int   n;
         logic m, p, e;
         n = int'($urandom_range(1, 20));
         m = 1'($urandom_range(0, 1));
         p = 1'($urandom_range(0, 1));
         fw.delete();
         for (int i = 0; i < n; i++) fw.push_back($urandom);
         send_frame(m, p, 1'($urandom_range(0, 1)), 1'b1);
         e = model_parity(m);
         take_result($sformatf("rnd%0d", f), e, p ^ e, (n > MAX_WORDS), model_len(n),
                     int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
